// File: rtl/fmap_buffer_if.sv
// Pixel-stream interface for the layer-1 -> layer-2 feature-map buffer.
// master drives the input stream and out_ready; slave is the buffer itself.
interface fmap_buffer_if #(
    parameter int unsigned OP = 8
);
    logic signed [OP:0] pxl_in;
    logic               in_valid;
    logic signed [OP:0] out_data;
    logic               out_valid;
    logic               out_ready;
    logic               out_last;
    logic               overflow;

    modport master (
        output pxl_in, in_valid, out_ready,
        input  out_data, out_valid, out_last, overflow
    );

    modport slave (
        input  pxl_in, in_valid, out_ready,
        output out_data, out_valid, out_last, overflow
    );
endinterface

// File: rtl/fmap_buffer.sv
// Ping-pong feature-map buffer: captures 14x14 pooled maps, re-streams them over valid/ready.
// Define RELU_EN to clamp negative pixels to zero on the write side.
module fmap_buffer #(
    parameter int unsigned OP    = 8,
    parameter int unsigned MAP_W = 14,
    parameter int unsigned MAP_H = 14
) (
    input logic         clk,
    input logic         reset,
    fmap_buffer_if.slave bus
);
    localparam int unsigned Depth = MAP_W * MAP_H;
    localparam int unsigned PtrW  = $clog2(Depth);
    localparam logic [PtrW-1:0] LastPtr = PtrW'(Depth - 1);

    typedef enum logic [1:0] {StIdle, StFetch, StStream} state_e;

    state_e             state_q, state_d;
    logic [1:0]         full_q, full_d;
    logic               wr_bank_q, wr_bank_d;
    logic               rd_bank_q, rd_bank_d;
    logic [PtrW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PtrW-1:0]    rd_addr;
    logic signed [OP:0] out_data_q, out_data_d;
    logic               out_valid_q, out_valid_d;
    logic               out_last_q, out_last_d;
    logic               overflow_q, overflow_d;
    logic signed [OP:0] wr_data;
    logic signed [OP:0] ram_q;
    logic               wr_en;
    logic               release_bank;
    logic               handshake;

    logic signed [OP:0] mem [2][Depth];

`ifdef RELU_EN
    assign wr_data = bus.pxl_in[OP] ? '0 : bus.pxl_in;
`else
    assign wr_data = bus.pxl_in;
`endif

    // Write side; a pixel arriving while the target bank is full is dropped.
    always_comb begin
        wr_en      = bus.in_valid && !full_q[wr_bank_q];
        wr_ptr_d   = wr_ptr_q;
        wr_bank_d  = wr_bank_q;
        overflow_d = overflow_q;
        full_d     = full_q;
        if (release_bank) begin
            full_d[rd_bank_q] = 1'b0;
        end
        if (wr_en) begin
            if (wr_ptr_q == LastPtr) begin
                wr_ptr_d          = '0;
                wr_bank_d         = ~wr_bank_q;
                full_d[wr_bank_q] = 1'b1;
            end else begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
        end else if (bus.in_valid) begin
            overflow_d = 1'b1;
        end
    end

    always_comb begin
        state_d      = state_q;
        rd_ptr_d     = rd_ptr_q;
        rd_bank_d    = rd_bank_q;
        out_data_d   = out_data_q;
        out_valid_d  = out_valid_q;
        out_last_d   = out_last_q;
        release_bank = 1'b0;
        handshake    = out_valid_q && bus.out_ready;
        unique case (state_q)
            StIdle: begin
                if (full_q[rd_bank_q]) begin
                    state_d = StFetch;
                end
            end
            StFetch: begin
                out_data_d  = ram_q;
                out_valid_d = 1'b1;
                out_last_d  = (rd_ptr_q == LastPtr);
                state_d     = StStream;
            end
            StStream: begin
                if (handshake) begin
                    if (rd_ptr_q == LastPtr) begin
                        out_valid_d  = 1'b0;
                        out_last_d   = 1'b0;
                        release_bank = 1'b1;
                        rd_bank_d    = ~rd_bank_q;
                        rd_ptr_d     = '0;
                        state_d      = StIdle;
                    end else begin
                        rd_ptr_d   = rd_ptr_q + 1'b1;
                        out_data_d = ram_q;
                        out_last_d = (rd_ptr_d == LastPtr);
                    end
                end
            end
            default: state_d = StIdle;
        endcase
        // RAM always holds the word after the one on the output, so a handshake can refill at once.
        if (state_q == StIdle || rd_ptr_d == LastPtr) begin
            rd_addr = '0;
        end else begin
            rd_addr = rd_ptr_d + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_bank_q][wr_ptr_q] <= wr_data;
        end
        ram_q <= mem[rd_bank_q][rd_addr];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= StIdle;
            full_q      <= '0;
            wr_bank_q   <= 1'b0;
            rd_bank_q   <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            full_q      <= full_d;
            wr_bank_q   <= wr_bank_d;
            rd_bank_q   <= rd_bank_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            overflow_q  <= overflow_d;
        end
    end

    assign bus.out_data  = out_data_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_last  = out_last_q;
    assign bus.overflow  = overflow_q;
endmodule

// File: tb/tb_fmap_buffer.sv
// Scoreboard bench for fmap_buffer: driver pushes expected pixels, negedge monitor pops and compares.
module tb_fmap_buffer;
    localparam int unsigned OP    = 8;
    localparam int unsigned MAP_W = 14;
    localparam int unsigned MAP_H = 14;
    localparam int N = MAP_W * MAP_H;

    typedef struct {
        int data;
        bit last;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;
    int   rdy_mode = 1;  // 0: stall, 1: always ready, 2: toggle
    int   hs_total = 0;
    exp_t exp_q[$];
    int   first_cyc[$];
    int   last_cyc[$];

    fmap_buffer_if #(.OP(OP)) bus ();

    fmap_buffer #(.OP(OP), .MAP_W(MAP_W), .MAP_H(MAP_H)) dut (
        .clk  (clk),
        .reset(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int got, input int expv);
        checks++;
        if (got != expv) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, expv, cyc);
        end
    endtask

    function automatic int pix(input int id, input int i);
        return ((i * 37 + id * 53) % 512) - 256;
    endfunction

    function automatic int model(input int v);
`ifdef RELU_EN
        return (v < 0) ? 0 : v;
`else
        return v;
`endif
    endfunction

    task automatic drive(input bit v, input int d);
        bus.in_valid = v;
        bus.pxl_in   = d[OP:0];
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) drive(1'b0, 0);
    endtask

    // id 0 is the 0..195 ramp; other ids give a signed pattern across the full range.
    task automatic send_map(input int id, input bit keep, input int count);
        for (int i = 0; i < count; i++) begin
            int v;
            v = (id == 0) ? i : pix(id, i);
            if (keep) exp_q.push_back('{data: model(v), last: (i == N - 1)});
            drive(1'b1, v);
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        bus.in_valid = 1'b0;
        while ((exp_q.size() != 0 || bus.out_valid) && n < 3000) begin
            @(posedge clk);
            #1;
            n++;
        end
        check(name, exp_q.size(), 0);
    endtask

    initial begin
        bus.out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       bus.out_ready = 1'b0;
                1:       bus.out_ready = 1'b1;
                default: bus.out_ready = ~bus.out_ready;
            endcase
        end
    end

    // Monitor: pops on every accepted transfer and checks the hold rule while stalled.
    initial begin
        bit   pv, pr, pl;
        int   pd;
        exp_t e;
        pv = 0; pr = 0; pl = 0; pd = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                pv = 0;
            end else begin
                if (pv && !pr) begin
                    check("hold_valid", bus.out_valid, 1);
                    check("hold_data", bus.out_data, pd);
                    check("hold_last", bus.out_last, pl);
                end
                if (bus.out_valid && !pv) first_cyc.push_back(cyc);
                if (bus.out_valid && bus.out_ready) begin
                    hs_total++;
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_output: got %0d expected no transfer (cycle %0d)",
                                 bus.out_data, cyc);
                    end else begin
                        e = exp_q.pop_front();
                        check("out_data", bus.out_data, e.data);
                        check("out_last", bus.out_last, e.last);
                    end
                    if (bus.out_last) last_cyc.push_back(cyc);
                end
                pv = bus.out_valid;
                pr = bus.out_ready;
                pl = bus.out_last;
                pd = bus.out_data;
            end
        end
    end

    initial begin
        int e1, e2, hs0;
        int t6_in [4];
        int t6_exp[4];
        t6_in = '{-256, -1, 0, 255};
`ifdef RELU_EN
        t6_exp = '{0, 0, 0, 255};
`else
        t6_exp = '{-256, -1, 0, 255};
`endif
        rst_n        = 1'b0;
        bus.in_valid = 1'b0;
        bus.pxl_in   = '0;
        #12;
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_out_last", bus.out_last, 0);
        check("rst_out_data", bus.out_data, 0);
        check("rst_overflow", bus.overflow, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(2);

        // Ramp map, always ready: latency and sustained streaming.
        rdy_mode = 1;
        first_cyc.delete();
        last_cyc.delete();
        send_map(0, 1'b1, N);
        e1 = cyc;
        wait_drain("t2_drain");
        check("t2_first_valid_latency", (first_cyc.size() > 0) ? first_cyc[0] - e1 : -1, 2);
        check("t2_burst_length",
              (first_cyc.size() > 0 && last_cyc.size() > 0) ? last_cyc[0] - first_cyc[0] : -1, N - 1);

        // Toggling ready: nothing lost or duplicated.
        idle(3);
        rdy_mode = 2;
        hs0 = hs_total;
        send_map(1, 1'b1, N);
        wait_drain("t3_drain");
        check("t3_transfers", hs_total - hs0, N);

        // Stalled consumer: third map dropped, then resume at pointer 0.
        idle(3);
        rdy_mode = 0;
        send_map(2, 1'b1, N);
        send_map(3, 1'b1, N);
        check("t4_no_overflow_yet", bus.overflow, 0);
        send_map(4, 1'b0, N);
        check("t4_overflow_set", bus.overflow, 1);
        rdy_mode = 1;
        wait_drain("t4_drain_two_maps");
        send_map(5, 1'b1, N);
        wait_drain("t4_resumed_map");
        check("t4_overflow_sticky", bus.overflow, 1);

        // Mid-stream asynchronous reset.
        rdy_mode = 0;
        send_map(6, 1'b1, N);
        idle(3);
        check("t1_pre_valid", bus.out_valid, 1);
        send_map(7, 1'b0, 50);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        check("t1_out_valid", bus.out_valid, 0);
        check("t1_out_last", bus.out_last, 0);
        check("t1_overflow", bus.overflow, 0);
        check("t1_out_data", bus.out_data, 0);
        @(posedge clk);
        #1;
        rst_n    = 1'b1;
        rdy_mode = 1;
        idle(2);

        // Back-to-back: bank 1 completes on the edge bank 0 is released.
        first_cyc.delete();
        last_cyc.delete();
        send_map(8, 1'b1, N);
        e1 = cyc;
        idle(2);
        send_map(9, 1'b1, N);
        e2 = cyc;
        send_map(10, 1'b1, N);
        wait_drain("t5_drain");
        check("t5_overflow", bus.overflow, 0);
        check("t5_first_latency", (first_cyc.size() > 0) ? first_cyc[0] - e1 : -1, 2);
        check("t5_same_edge", (last_cyc.size() > 0) ? e2 - last_cyc[0] : -1, 1);
        check("t5_map_gap", (first_cyc.size() > 1) ? first_cyc[1] - last_cyc[0] : -1, 3);

        // Signed boundary values through the optional clamp.
        for (int i = 0; i < N; i++) begin
            int v;
            v = (i < 4) ? t6_in[i] : pix(11, i);
            exp_q.push_back('{data: (i < 4) ? t6_exp[i] : model(v), last: (i == N - 1)});
            drive(1'b1, v);
        end
        wait_drain("t6_drain");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
